axi_full_slave_mem: RTL and testbench
=====================================

AXI_FULL_SLAVE_MEM -- requirements
Module: axi_full_slave_mem

Interface
REQ-001 C_S_AXI_ID_WIDTH, 1, width of all ID signals.
REQ-002 C_S_AXI_DATA_WIDTH, 32, data width; fixed at 32 (4-byte beats).
REQ-003 C_S_AXI_ADDR_WIDTH, 10, byte address width; memory depth = 2^(ADDR_W-2) words (256).
REQ-004 S_AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-005 S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-006 AW channel, all in except READY: S_AXI_AWID (ID_W), S_AXI_AWADDR (ADDR_W), S_AXI_AWLEN (8), S_AXI_AWSIZE (3), S_AXI_AWBURST (2), S_AXI_AWVALID (1); S_AXI_AWREADY out 1.
REQ-007 W channel: S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WLAST in 1, S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-008 B channel: S_AXI_BID out ID_W, S_AXI_BRESP out 2, S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-009 AR channel: S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID in (widths as AW); S_AXI_ARREADY out 1.
REQ-010 R channel: S_AXI_RID out ID_W, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-011 WR_BEAT_CNT  out  32  count of accepted W beats; RD_BEAT_CNT  out  32  count of completed R beats.
REQ-012 LOCK/CACHE/PROT/QOS/REGION/USER are not implemented.

Function
REQ-013 Write and read paths are independent FSMs; one outstanding burst per direction.
REQ-014 Write FSM states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-015 W_IDLE: on AWVALID&AWREADY capture ID, ADDR, LEN, SIZE, BURST, clear beat counter, go W_DATA next cycle.
REQ-016 W_DATA: each WVALID&WREADY writes mem[addr[ADDR_W-1:2]] bytes enabled by WSTRB, increments beat counter.
REQ-017 Address update per beat: INCR (2'b01) +4, wrapping modulo memory size; FIXED (2'b00) unchanged.
REQ-018 Burst ends on beat LEN+1 regardless of WLAST; FSM then enters W_RESP.
REQ-019 BRESP=SLVERR (2'b10) if WLAST=0 on final beat, WLAST=1 on any earlier beat, BURST=WRAP/reserved, or SIZE!=3'b010; otherwise OKAY.
REQ-020 Error bursts (BURST or SIZE error) still consume LEN+1 beats but write nothing to memory.
REQ-021 W_RESP: BID=captured ID; BVALID held until BREADY; W_IDLE the cycle after handshake.
REQ-022 Read FSM states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-023 On AR handshake capture fields; RVALID=1 the next cycle with RDATA=mem[first addr] registered.
REQ-024 Each RVALID&RREADY advances address (rules of REQ-017) and loads next word; RDATA/RLAST stable while RVALID&!RREADY.
REQ-025 RLAST=1 exactly on beat LEN+1; after its handshake RVALID=0, R_IDLE next cycle.
REQ-026 RID=captured ID; RRESP=SLVERR with RDATA=0 for BURST or SIZE error bursts, else OKAY.
REQ-027 Same-word read-load and write in one cycle: read returns pre-write data.
REQ-028 Address bits above ADDR_W and bits [1:0] ignored; no 4 KB boundary check.
REQ-029 WR_BEAT_CNT/RD_BEAT_CNT increment per handshake beat (error bursts included), saturate at 0xFFFFFFFF.

Reset
REQ-030 ARESET=1 asynchronously forces W_IDLE/R_IDLE, all VALID/READY outputs 0, BRESP/RRESP/RDATA/BID/RID/RLAST 0, counters 0.
REQ-031 AWREADY and ARREADY rise on the first rising clock edge after ARESET deasserts.
REQ-032 Memory contents are not reset; beats written before a mid-burst reset remain; the abandoned burst gets no response.

Verification
REQ-033 AW addr 0x010 LEN=3 INCR, data 0x11..0x44 WSTRB=F, WLAST on beat 4 -> BRESP OKAY; AR same -> RDATA 0x11,0x22,0x33,0x44, RLAST beat 4.
REQ-034 Write 0xAABBCCDD to 0x020, then WSTRB=4'b0101 data 0x00000000 -> read 0xAA00CC00.
REQ-035 AW 0x3FC LEN=1 INCR -> beats land at words 255 and 0; read-back matches.
REQ-036 AW LEN=1 with WLAST=1 on beat 1 -> BRESP SLVERR, 2 beats accepted; AWBURST=2'b10 -> SLVERR, memory unchanged, R of WRAP returns 0/SLVERR.
REQ-037 RREADY held 0 for 5 cycles during LEN=2 read -> RVALID/RDATA stable; RD_BEAT_CNT=3 afterward.
REQ-038 ARESET pulsed mid write burst at beat 2 of LEN=7 -> outputs 0 immediately, no BVALID, AWREADY=1 one edge after release.

Source files
------------

// File: rtl/axi_full_slave_mem.sv
// AXI4 full slave backed by a 256-word byte-writable memory.
// Independent single-outstanding write and read burst engines.
module axi_full_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     WR_BEAT_CNT,
    output logic [31:0]                     RD_BEAT_CNT
);
    localparam int WW    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WW;
    localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

    wstate_t                       wstate_q;
    logic                          awready_q, wready_q, bvalid_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   bid_q;
    logic [WW-1:0]                 waddr_q, waddr_d;
    logic [7:0]                    wlen_q, wbeat_q;
    logic [1:0]                    wburst_q;
    logic                          werr_q, wlast_err_q, wlast_err_d;
    logic                          wr_fire, wbeat_last;

    rstate_t                       rstate_q;
    logic                          arready_q, rvalid_q, rlast_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [WW-1:0]                 raddr_q, raddr_d, ar_word;
    logic [7:0]                    rlen_q, rbeat_q;
    logic [1:0]                    rburst_q;
    logic                          rerr_q, ar_err, rd_fire;

    logic [31:0]                   wr_cnt_q, rd_cnt_q;
    logic                          unused_addr_lsbs;

    // Only FIXED and INCR with full-width beats are serviced.
    function automatic logic burst_err(input logic [1:0] burst,
                                       input logic [2:0] size);
        return burst[1] || (size != 3'b010);
    endfunction

    function automatic logic [WW-1:0] next_addr(input logic [WW-1:0] a,
                                                input logic [1:0] burst);
        return (burst == 2'b01) ? a + 1'b1 : a;
    endfunction

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_fire     = wready_q && S_AXI_WVALID;
    assign wbeat_last  = (wbeat_q == wlen_q);
    assign waddr_d     = next_addr(waddr_q, wburst_q);
    assign wlast_err_d = wlast_err_q || (S_AXI_WLAST != wbeat_last);

    assign rd_fire = rvalid_q && S_AXI_RREADY;
    assign raddr_d = next_addr(raddr_q, rburst_q);
    assign ar_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_err  = burst_err(S_AXI_ARBURST, S_AXI_ARSIZE);

    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_fire && !werr_q) begin
            for (int b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) mem_q[waddr_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wstate_q    <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            bid_q       <= '0;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wbeat_q     <= '0;
            wburst_q    <= '0;
            werr_q      <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            unique case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (S_AXI_AWVALID && awready_q) begin
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        bid_q       <= S_AXI_AWID;
                        waddr_q     <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        wlen_q      <= S_AXI_AWLEN;
                        wburst_q    <= S_AXI_AWBURST;
                        werr_q      <= burst_err(S_AXI_AWBURST, S_AXI_AWSIZE);
                        wbeat_q     <= '0;
                        wlast_err_q <= 1'b0;
                        wstate_q    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wr_fire) begin
                        waddr_q     <= waddr_d;
                        wbeat_q     <= wbeat_q + 8'd1;
                        wlast_err_q <= wlast_err_d;
                        if (wbeat_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (werr_q || wlast_err_d) ? SLVERR : OKAY;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Memory is sampled here with <=, so a same-cycle write is not visible.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
        end else begin
            unique case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (S_AXI_ARVALID && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= S_AXI_ARID;
                        raddr_q   <= ar_word;
                        rlen_q    <= S_AXI_ARLEN;
                        rburst_q  <= S_AXI_ARBURST;
                        rerr_q    <= ar_err;
                        rbeat_q   <= '0;
                        rdata_q   <= ar_err ? '0 : mem_q[ar_word];
                        rresp_q   <= ar_err ? SLVERR : OKAY;
                        rlast_q   <= (S_AXI_ARLEN == 8'd0);
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rd_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_d;
                            rbeat_q <= rbeat_q + 8'd1;
                            rdata_q <= rerr_q ? '0 : mem_q[raddr_d];
                            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_fire && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (rd_fire && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = rid_q;
    assign WR_BEAT_CNT   = wr_cnt_q;
    assign RD_BEAT_CNT   = rd_cnt_q;

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Directed bench for axi_full_slave_mem: bursts, strobes, wrap,
// error responses, read backpressure and mid-burst reset.
module tb_axi_full_slave_mem;
    localparam int LIM = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  awid, bid, arid, rid;
    logic [9:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata, wr_cnt, rd_cnt;
    logic [3:0]  wstrb;

    int          checks = 0;
    int          fails  = 0;
    int          ewr    = 0;
    int          erd    = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic        rl [16];
    logic [31:0] exp3 [3];
    logic [1:0]  br, rr;
    logic        bid_s, rid_s;

    always #5 clk = ~clk;

    axi_full_slave_mem dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .WR_BEAT_CNT(wr_cnt), .RD_BEAT_CNT(rd_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [9:0] a, input logic [7:0] len,
                          input logic [1:0] bt, input int lastb, input logic id);
        int n;
        awid = id; awaddr = a; awlen = len; awburst = bt;
        awsize = 3'b010; awvalid = 1'b1;
        n = 0;
        while (!awready && n < LIM) begin @(negedge clk); n++; end
        chk("aw_handshake", 32'(n < LIM), 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == lastb); wvalid = 1'b1;
            n = 0;
            while (!wready && n < LIM) begin @(negedge clk); n++; end
            if (n >= LIM) chk("w_handshake", 32'(n), 0);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        ewr += int'(len) + 1;
        n = 0;
        while (!bvalid && n < LIM) begin @(negedge clk); n++; end
        chk("b_handshake", 32'(n < LIM), 1);
        br = bresp; bid_s = bid;
        @(negedge clk);
        bready = 1'b0;
        chk("wr_beat_cnt", wr_cnt, 32'(ewr));
    endtask

    task automatic axi_rd(input logic [9:0] a, input logic [7:0] len,
                          input logic [1:0] bt, input logic id);
        int n;
        arid = id; araddr = a; arlen = len; arburst = bt;
        arsize = 3'b010; arvalid = 1'b1;
        n = 0;
        while (!arready && n < LIM) begin @(negedge clk); n++; end
        chk("ar_handshake", 32'(n < LIM), 1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!rvalid && n < LIM) begin @(negedge clk); n++; end
            if (n >= LIM) chk("r_handshake", 32'(n), 0);
            rd[i] = rdata; rl[i] = rlast; rr = rresp; rid_s = rid;
            @(negedge clk);
        end
        rready = 1'b0;
        erd += int'(len) + 1;
        chk("rvalid_after_last", 32'(rvalid), 0);
        chk("rd_beat_cnt", rd_cnt, 32'(erd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        rst = 1'b0;
        #1 chk("awready_before_edge", 32'(awready), 0);
        @(negedge clk);
        chk("awready_after_edge", 32'(awready), 1);
        chk("arready_after_edge", 32'(arready), 1);

        // basic 4-beat INCR
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 16; i++) ws[i] = 4'hF;
        axi_wr(10'h010, 8'd3, 2'b01, 3, 1'b1);
        chk("incr_bresp", 32'(br), 0);
        chk("incr_bid", 32'(bid_s), 1);
        axi_rd(10'h010, 8'd3, 2'b01, 1'b1);
        chk("incr_rd0", rd[0], 32'h11);
        chk("incr_rd1", rd[1], 32'h22);
        chk("incr_rd2", rd[2], 32'h33);
        chk("incr_rd3", rd[3], 32'h44);
        chk("incr_rlast", {28'd0, rl[3], rl[2], rl[1], rl[0]}, 32'b1000);
        chk("incr_rresp", 32'(rr), 0);
        chk("incr_rid", 32'(rid_s), 1);

        // byte strobes
        wd[0] = 32'hAABBCCDD;
        axi_wr(10'h020, 8'd0, 2'b01, 0, 1'b0);
        wd[0] = 32'h0; ws[0] = 4'b0101;
        axi_wr(10'h020, 8'd0, 2'b01, 0, 1'b0);
        ws[0] = 4'hF;
        axi_rd(10'h020, 8'd0, 2'b01, 1'b0);
        chk("strobe_merge", rd[0], 32'hAA00CC00);

        // address wraps past the top word
        wd[0] = 32'h55; wd[1] = 32'h66;
        axi_wr(10'h3FC, 8'd1, 2'b01, 1, 1'b0);
        chk("wrap_bresp", 32'(br), 0);
        axi_rd(10'h3FC, 8'd1, 2'b01, 1'b0);
        chk("wrap_rd0", rd[0], 32'h55);
        chk("wrap_rd1", rd[1], 32'h66);
        axi_rd(10'h000, 8'd0, 2'b01, 1'b0);
        chk("wrap_word0", rd[0], 32'h66);

        // FIXED burst keeps hitting one word
        wd[0] = 32'hA1; wd[1] = 32'hB2; wd[2] = 32'hC3;
        axi_wr(10'h080, 8'd2, 2'b00, 2, 1'b0);
        chk("fixed_bresp", 32'(br), 0);
        axi_rd(10'h080, 8'd1, 2'b00, 1'b0);
        chk("fixed_rd0", rd[0], 32'hC3);
        chk("fixed_rd1", rd[1], 32'hC3);

        // WLAST protocol errors
        wd[0] = 32'h77; wd[1] = 32'h88;
        axi_wr(10'h100, 8'd1, 2'b01, 0, 1'b0);
        chk("early_wlast_bresp", 32'(br), 2);
        axi_rd(10'h100, 8'd1, 2'b01, 1'b0);
        chk("early_wlast_data", rd[1], 32'h88);
        wd[0] = 32'h99;
        axi_wr(10'h108, 8'd0, 2'b01, -1, 1'b0);
        chk("no_wlast_bresp", 32'(br), 2);

        // WRAP burst type rejected on both paths
        wd[0] = 32'hDEAD;
        axi_wr(10'h010, 8'd0, 2'b10, 0, 1'b0);
        chk("wrap_type_bresp", 32'(br), 2);
        axi_rd(10'h010, 8'd0, 2'b01, 1'b0);
        chk("wrap_type_nowrite", rd[0], 32'h11);
        axi_rd(10'h010, 8'd0, 2'b10, 1'b0);
        chk("wrap_type_rdata", rd[0], 0);
        chk("wrap_type_rresp", 32'(rr), 2);

        // reset in the middle of an 8-beat write
        awid = 1'b0; awaddr = 10'h040; awlen = 8'd7; awburst = 2'b01;
        awsize = 3'b010; awvalid = 1'b1;
        n = 0;
        while (!awready && n < LIM) begin @(negedge clk); n++; end
        chk("mid_aw_handshake", 32'(n < LIM), 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hB0 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            n = 0;
            while (!wready && n < LIM) begin @(negedge clk); n++; end
            if (n >= LIM) chk("mid_w_handshake", 32'(n), 0);
            @(negedge clk);
        end
        wdata = 32'hB2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wready", 32'(wready), 0);
        chk("mid_rst_awready", 32'(awready), 0);
        chk("mid_rst_wr_cnt", wr_cnt, 0);
        chk("mid_rst_rd_cnt", rd_cnt, 0);
        wvalid = 1'b0;
        ewr = 0; erd = 0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_awready_before_edge", 32'(awready), 0);
        @(negedge clk);
        chk("mid_awready_after_edge", 32'(awready), 1);
        repeat (3) @(negedge clk);
        chk("mid_no_bvalid", 32'(bvalid), 0);

        // read backpressure: hold RREADY low for 5 cycles
        exp3[0] = 32'h11; exp3[1] = 32'h22; exp3[2] = 32'h33;
        arid = 1'b0; araddr = 10'h010; arlen = 8'd2; arburst = 2'b01;
        arsize = 3'b010; arvalid = 1'b1;
        n = 0;
        while (!arready && n < LIM) begin @(negedge clk); n++; end
        chk("bp_ar_handshake", 32'(n < LIM), 1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold_rvalid%0d", c), 32'(rvalid), 1);
            chk($sformatf("bp_hold_rdata%0d", c), rdata, 32'h11);
            @(negedge clk);
        end
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!rvalid && n < LIM) begin @(negedge clk); n++; end
            if (n >= LIM) chk("bp_r_handshake", 32'(n), 0);
            chk($sformatf("bp_rdata%0d", i), rdata, exp3[i]);
            chk($sformatf("bp_rlast%0d", i), 32'(rlast), 32'(i == 2));
            @(negedge clk);
        end
        rready = 1'b0;
        erd = 3;
        chk("bp_rd_cnt", rd_cnt, 3);

        // beats accepted before the reset are kept
        axi_rd(10'h040, 8'd1, 2'b01, 1'b0);
        chk("mid_kept0", rd[0], 32'hB0);
        chk("mid_kept1", rd[1], 32'hB1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
